// File: rtl/secded_pkg.sv
// Shared types and SECDED helpers for the 13-bit scrubber: code geometry, FSM states,
// error classes, and syndrome/parity functions.
package secded_pkg;

    localparam int CODE_W = 13;
    localparam int SYN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_CLEAN  = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2
    } err_class_e;

    // Bit k of the syndrome covers every position 1..12 whose index has bit k set.
    function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CODE_W-1:0] word);
        logic [SYN_W-1:0] syn;
        logic [SYN_W-1:0] idx;
        syn = {SYN_W{1'b0}};
        for (int i = 1; i < CODE_W; i++) begin
            idx = SYN_W'(i);
            for (int k = 0; k < SYN_W; k++) begin
                if (idx[k]) begin
                    syn[k] = syn[k] ^ word[i];
                end
            end
        end
        return syn;
    endfunction

    function automatic logic calc_parity(input logic [CODE_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/secded_classify.sv
// Combinational SECDED decoder: classifies a 13-bit codeword and produces the
// single-bit-corrected word. Shared by the scrubber and the host read path.
module secded_classify
    import secded_pkg::*;
(
    input  logic [CODE_W-1:0] word,
    output err_class_e        err_class,
    output logic [CODE_W-1:0] corrected
);

    logic [SYN_W-1:0] syn_s;
    logic             par_s;

    // Decode syndrome and overall parity into an error class and repaired word
    always_comb begin
        syn_s     = calc_syndrome(word);
        par_s     = calc_parity(word);
        err_class = ERR_CLEAN;
        corrected = word;
        if (!par_s) begin
            if (syn_s == 4'd0) begin
                err_class = ERR_CLEAN;
            end else begin
                err_class = ERR_DOUBLE;
            end
        end else begin
            // Syndrome 0 with odd parity means the overall parity bit itself flipped
            if (syn_s <= 4'd12) begin
                err_class = ERR_SINGLE;
                corrected = word ^ (13'd1 << syn_s);
            end else begin
                err_class = ERR_DOUBLE;
            end
        end
    end

endmodule

// File: rtl/secded_scrubber.sv
// Background scrubber walking DEPTH SECDED words, yielding the port to the host on request.
// Define SCRUB_WRITEBACK_EN to write single-bit corrections back; otherwise report-only.
module secded_scrubber
    import secded_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              host_req,
    output logic              host_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [CODE_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [CODE_W-1:0] mem_wdata,
    output logic [7:0]        corr_count,
    output logic [7:0]        uncorr_count,
    output logic [ADDR_W-1:0] first_bad_addr,
    output logic              first_bad_vld
);

    state_e            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        corr_r;
    logic [7:0]        uncorr_r;
    logic [ADDR_W-1:0] fba_r;
    logic              fbv_r;
    logic              busy_r;
    logic              done_r;
    err_class_e        cls_s;
    logic [CODE_W-1:0] fixed_s;
    logic              last_s;
    logic              advance_s;

    secded_classify u_classify (
        .word      (mem_rdata),
        .err_class (cls_s),
        .corrected (fixed_s)
    );

    // Decide when the walk moves past the current word
    always_comb begin
        last_s    = (addr_r == ADDR_W'(DEPTH - 1));
        advance_s = 1'b0;
        if (state_r == ST_CHECK) begin
`ifdef SCRUB_WRITEBACK_EN
            advance_s = (cls_s != ERR_SINGLE);
`else
            advance_s = 1'b1;
`endif
        end else if (state_r == ST_WRITE) begin
            advance_s = !host_req;
        end else begin
            advance_s = 1'b0;
        end
    end

`ifdef SCRUB_WRITEBACK_EN
    logic [CODE_W-1:0] wdata_r;

    // Hold the corrected word from the decode cycle until the write is granted
    always_ff @(posedge clock) begin
        if (reset) begin
            wdata_r <= {CODE_W{1'b0}};
        end else if (state_r == ST_CHECK && cls_s == ERR_SINGLE) begin
            wdata_r <= fixed_s;
        end
    end

    assign mem_we    = (state_r == ST_WRITE) && !host_req && !reset;
    assign mem_wdata = wdata_r;
`else
    logic unused_fixed_s;
    assign unused_fixed_s = ^fixed_s;
    assign mem_we         = 1'b0;
    assign mem_wdata      = {CODE_W{1'b0}};
`endif

    // Scrub FSM with pass statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            addr_r   <= {ADDR_W{1'b0}};
            corr_r   <= 8'd0;
            uncorr_r <= 8'd0;
            fba_r    <= {ADDR_W{1'b0}};
            fbv_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        corr_r   <= 8'd0;
                        uncorr_r <= 8'd0;
                        fbv_r    <= 1'b0;
                        addr_r   <= {ADDR_W{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!host_req) begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    case (cls_s)
                        ERR_SINGLE: begin
                            if (corr_r != 8'hFF) begin
                                corr_r <= corr_r + 8'd1;
                            end
`ifdef SCRUB_WRITEBACK_EN
                            state_r <= ST_WRITE;
`endif
                        end
                        ERR_DOUBLE: begin
                            if (uncorr_r != 8'hFF) begin
                                uncorr_r <= uncorr_r + 8'd1;
                            end
                            if (!fbv_r) begin
                                fba_r <= addr_r;
                                fbv_r <= 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                ST_WRITE: begin
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            if (advance_s) begin
                if (last_s) begin
                    state_r <= ST_DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end else begin
                    addr_r  <= addr_r + ADDR_W'(1);
                    state_r <= ST_READ;
                end
            end
        end
    end

    // The host only waits through the decode cycle of a read-modify-write
    assign host_gnt       = host_req && (state_r != ST_CHECK);
    assign mem_re         = (state_r == ST_READ) && !host_req && !reset;
    assign mem_addr       = addr_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign corr_count     = corr_r;
    assign uncorr_count   = uncorr_r;
    assign first_bad_addr = fba_r;
    assign first_bad_vld  = fbv_r;

endmodule

// File: doc/secded_scrubber.md
# secded_scrubber

Background memory scrubber that walks every word of a 13-bit SECDED-protected memory, decodes each word and writes single-bit corrections back in place. It owns the memory port when the host is idle, yields it to a host requester on demand, and keeps saturating error statistics. It sits between the host memory interface and a single-port synchronous RAM.

## Interface
- DEPTH, 16, number of 13-bit words scrubbed (addresses 0..DEPTH-1; DEPTH ≥ 2)
- ADDR_W, $clog2(DEPTH), address width (derived, do not override)
- clock  input  1  sole clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  begin one full pass; sampled only in IDLE
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse at end of pass
- host_req  input  1  host wants the memory port this cycle
- host_gnt  output  1  host owns memory port this cycle (combinational from host_req and state)
- mem_addr  output  ADDR_W  scrubber address (ignored by mux when host_gnt)
- mem_re  output  1  scrubber read strobe; mem_rdata valid next cycle
- mem_rdata  input  13  read data, 1-cycle latency
- mem_we  output  1  scrubber write strobe
- mem_wdata  output  13  corrected word
- corr_count  output  8  single-bit errors found this pass, saturates at 255
- uncorr_count  output  8  uncorrectable words this pass, saturates at 255
- first_bad_addr  output  ADDR_W  address of first uncorrectable word
- first_bad_vld  output  1  first_bad_addr is valid

## Operation
- Code layout: bit 0 overall parity; bits 1,2,4,8 Hamming check bits; data elsewhere. syndrome[k] = XOR of bits i in 1..12 with bit k of i set. parity = XOR of all 13 bits.
- Classification: parity=0, syndrome=0 → clean. parity=1, syndrome in 0..12 → single error, flip bit[syndrome] (syndrome 0 flips bit 0). parity=0, syndrome≠0 → double error. parity=1, syndrome 13..15 → uncorrectable (counted as double).
- FSM: IDLE, READ, CHECK, WRITE, DONE.
  - IDLE: start → clear counters, first_bad_vld, addr=0; go READ.
  - READ: if host_req, host_gnt=1, no mem_re, stay. Else mem_re=1 at addr, go CHECK.
  - CHECK: classify mem_rdata. Single → corr_count++, capture corrected word, go WRITE. Uncorrectable → uncorr_count++, capture first_bad_addr if !first_bad_vld; then advance. Clean → advance.
  - WRITE: if host_req, host_gnt=1, stay. Else mem_we=1, mem_wdata=corrected word; advance.
  - Advance: addr==DEPTH-1 → DONE; else addr++, READ.
  - DONE: done=1 one cycle, busy=0, go IDLE.
- host_gnt = host_req in IDLE, READ, WRITE, DONE; 0 in CHECK (protects read-modify-write ordering only across the decode cycle; host is responsible for not writing the address being scrubbed between READ and WRITE).
- start while busy is ignored. Counters and first_bad_* hold after done until next accepted start.

## Timing
- Reset: state IDLE, busy=0, done=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, counters 0, first_bad_addr=0, first_bad_vld=0. Reset mid-pass aborts immediately; no write issued in the reset cycle.
- No host traffic, no errors: start at cycle 0 → busy from cycle 1, done at cycle 2·DEPTH+1.
- Each single-bit error adds 1 cycle; each host-granted cycle in READ/WRITE adds 1 cycle.
- Max host wait: 1 cycle (CHECK).
- Counter at 255 stays 255.

## Configuration
- SCRUB_WRITEBACK_EN defined: behaviour above.
- Not defined: report-only; WRITE never entered, mem_we tied 0, mem_wdata tied 0, single errors still counted; pass length independent of error count.

## Structure
- Package secded_pkg: code width 13, syndrome width 4, FSM state enum, error-class enum (CLEAN, SINGLE, DOUBLE).
- Sub-module secded_classify: combinational, mem_rdata in → error class and corrected word out; reused by host-side read path.

## Test plan
- DEPTH=16, all words 13'h0000, no host_req → done at cycle 33, corr=0, uncorr=0, no mem_we.
- Word 5 = 13'h0020 → one write at addr 5 of 13'h0000, corr=1, done at cycle 34.
- Word 3 = 13'h0006, word 9 = 13'h0112 → uncorr=2, first_bad_addr=3, no writes.
- Word 0 = 13'h0001 → write 13'h0000 at addr 0, corr=1; without SCRUB_WRITEBACK_EN corr=1, no write.
- host_req held 3 cycles during READ of addr 2 → host_gnt high 3 cycles, no mem_re meanwhile, done delayed by 3; host_req during CHECK → host_gnt=0.
- 300 corrupted words (DEPTH=512) → corr saturates at 255; reset asserted mid-pass → all outputs reset values next cycle.
